d_sequencer: RTL and testbench

//   Multi-block transfer sequencer for the SD DAT-line driver (d_driver).

---
 rtl/d_sequencer.sv | 152 +++++++++++++++
 tb/tb_d_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_sequencer.sv
// Multi-block transfer sequencer for the SD DAT-line driver.
// Issues per-block start pulses, retries CRC failures, waits out card busy.
module d_sequencer #(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ireq_read,
  input  logic             ireq_write,
  input  logic [CNT_W-1:0] inum_blocks,
  output logic             ostart_read,
  output logic             ostart_write,
  input  logic             idone,
  input  logic             icrc_fail,
  input  logic             idat0,
  output logic             obusy,
  output logic [CNT_W-1:0] oblk_cnt,
  output logic             odone,
  output logic             oerror,
  output logic             oerr_crc,
  output logic             oerr_timeout
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_BUSY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] blk_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             crc_d, to_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    count_d = count_q;
    blk_d   = oblk_cnt;
    retry_d = retry_q;
    timer_d = timer_q;
    crc_d   = oerr_crc;
    to_d    = oerr_timeout;
    unique case (state_q)
      S_IDLE: begin
        if (ireq_read || ireq_write) begin
          // dir: 1 = write; read wins a tie
          dir_d   = !ireq_read;
          count_d = (inum_blocks == '0) ? CNT_W'(1)
                                        : inum_blocks;
          blk_d   = '0;
          retry_d = '0;
          crc_d   = 1'b0;
          to_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (idone) begin
          if (!icrc_fail) begin
            if (dir_q) begin
              timer_d = '0;
              state_d = S_BUSY;
            end else begin
              state_d = S_NEXT;
            end
          end else if (retry_q < R_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_START;
          end else begin
            crc_d   = 1'b1;
            state_d = S_ERROR;
          end
        end else if (timer_q == T_LAST) begin
          to_d    = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_BUSY: begin
        timer_d = timer_q + TW'(1);
        if (idat0) begin
          state_d = S_NEXT;
        end else if (timer_q == T_LAST) begin
          to_d    = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_NEXT: begin
        blk_d   = oblk_cnt + CNT_W'(1);
        retry_d = '0;
        state_d = (blk_d == count_q) ? S_DONE
                                     : S_START;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      count_q      <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      oblk_cnt     <= '0;
      oerr_crc     <= 1'b0;
      oerr_timeout <= 1'b0;
      ostart_read  <= 1'b0;
      ostart_write <= 1'b0;
      obusy        <= 1'b0;
      odone        <= 1'b0;
      oerror       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      oblk_cnt     <= blk_d;
      oerr_crc     <= crc_d;
      oerr_timeout <= to_d;
      ostart_read  <= (state_d == S_START) && !dir_d;
      ostart_write <= (state_d == S_START) && dir_d;
      obusy        <= (state_d != S_IDLE);
      odone        <= (state_d == S_DONE);
      oerror       <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_d_sequencer.sv
// Directed testbench for d_sequencer.
// A behavioural d_driver/card responder runs inside the per-cycle tick.
module tb_d_sequencer;

  logic       iclk = 0;
  logic       irst = 0;
  logic       ireq_read = 0;
  logic       ireq_write = 0;
  logic [7:0] inum_blocks = 0;
  logic       ostart_read, ostart_write;
  logic       idone = 0;
  logic       icrc_fail = 0;
  logic       idat0 = 1;
  logic       obusy;
  logic [7:0] oblk_cnt;
  logic       odone, oerror, oerr_crc, oerr_timeout;

  d_sequencer #(.CNT_W(8), .MAX_RETRY(3), .TIMEOUT(100)) dut (
    .iclk(iclk), .irst(irst),
    .ireq_read(ireq_read), .ireq_write(ireq_write),
    .inum_blocks(inum_blocks),
    .ostart_read(ostart_read), .ostart_write(ostart_write),
    .idone(idone), .icrc_fail(icrc_fail), .idat0(idat0),
    .obusy(obusy), .oblk_cnt(oblk_cnt),
    .odone(odone), .oerror(oerror),
    .oerr_crc(oerr_crc), .oerr_timeout(oerr_timeout)
  );

  always #5 iclk = ~iclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_rd, n_wr, n_done, n_err, err_cyc;
  int start_cyc[$];
  int rise_cyc[$];
  int blk_hist[$];
  logic [7:0] last_blk;
  bit respond;
  int delay, busy_lo, n_fail, att;
  int wait_c, busy_c;
  bit last_wr;

  task automatic clear();
    n_rd = 0; n_wr = 0; n_done = 0; n_err = 0;
    err_cyc = -1; att = 0; wait_c = -1; busy_c = 0;
    start_cyc.delete(); rise_cyc.delete();
    blk_hist.delete(); last_blk = oblk_cnt;
  endtask

  task automatic tick();
    @(negedge iclk);
    cyc++;
    idone = 0;
    icrc_fail = 0;
    if (busy_c > 0) begin
      busy_c--;
      if (busy_c == 0) begin
        idat0 = 1;
        rise_cyc.push_back(cyc);
      end
    end
    if (ostart_read || ostart_write) begin
      if (ostart_read) n_rd++;
      if (ostart_write) n_wr++;
      start_cyc.push_back(cyc);
      last_wr = ostart_write;
      wait_c = respond ? delay : -1;
    end else if (wait_c > 0) begin
      wait_c--;
      if (wait_c == 0) begin
        idone = 1;
        icrc_fail = (att < n_fail);
        att++;
        if (last_wr && !icrc_fail) begin
          idat0 = 0;
          busy_c = busy_lo;
        end
        wait_c = -1;
      end
    end
    if (oblk_cnt != last_blk) begin
      blk_hist.push_back(int'(oblk_cnt));
      last_blk = oblk_cnt;
    end
    if (odone) n_done++;
    if (oerror) begin
      n_err++;
      err_cyc = cyc;
    end
  endtask

  task automatic req(input bit rd, input bit wr,
                     input logic [7:0] n);
    ireq_read = rd;
    ireq_write = wr;
    inum_blocks = n;
    tick();
    ireq_read = 0;
    ireq_write = 0;
  endtask

  task automatic run_end(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (odone || oerror) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    irst = 0;
    tick(); tick();
    tests++;
    if ({ostart_read, ostart_write, obusy, odone, oerror,
         oerr_crc, oerr_timeout, oblk_cnt} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b%b cnt=%0d want all 0",
               ostart_read, ostart_write, obusy, odone, oerror,
               oerr_crc, oerr_timeout, oblk_cnt);
    end
    irst = 1;
    tick();
  endtask

  task automatic test_read_multi();
    bit ok;
    clear();
    respond = 1; delay = 10; busy_lo = 0; n_fail = 0;
    req(1, 0, 8'd3);
    run_end(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rd3_end got=timeout want odone"); end
    tests++;
    if (n_rd != 3 || n_wr != 0) begin
      fails++; $display("FAIL rd3_pulses got rd=%0d wr=%0d want 3/0", n_rd, n_wr);
    end
    tests++;
    if (n_done != 1 || n_err != 0) begin
      fails++; $display("FAIL rd3_status got done=%0d err=%0d want 1/0", n_done, n_err);
    end
    tests++;
    if (blk_hist.size() != 3 || blk_hist[0] != 1 || blk_hist[1] != 2 || blk_hist[2] != 3) begin
      fails++; $display("FAIL rd3_blkseq got n=%0d last=%0d want 1,2,3", blk_hist.size(), oblk_cnt);
    end
    tick();
    tests++;
    if (obusy !== 1'b0 || oblk_cnt !== 8'd3) begin
      fails++; $display("FAIL rd3_after got busy=%b cnt=%0d want 0/3", obusy, oblk_cnt);
    end
  endtask

  task automatic test_write_busy();
    bit ok;
    clear();
    respond = 1; delay = 4; busy_lo = 5; n_fail = 0;
    req(0, 1, 8'd2);
    run_end(200, ok);
    tests++;
    if (!ok || n_done != 1 || n_wr != 2 || n_rd != 0) begin
      fails++; $display("FAIL wr2_status got ok=%0d done=%0d wr=%0d rd=%0d want 1/1/2/0", ok, n_done, n_wr, n_rd);
    end
    tests++;
    if (start_cyc.size() < 2 || rise_cyc.size() < 1 || start_cyc[1] != rise_cyc[0] + 2) begin
      fails++; $display("FAIL wr2_busywait got starts=%0d rises=%0d want start2 = rise+2", start_cyc.size(), rise_cyc.size());
    end
    tests++;
    if (oblk_cnt !== 8'd2) begin
      fails++; $display("FAIL wr2_cnt got=%0d want=2", oblk_cnt);
    end
    tick();
  endtask

  task automatic test_crc_retry();
    bit ok;
    clear();
    respond = 1; delay = 3; busy_lo = 0; n_fail = 2;
    req(1, 0, 8'd1);
    run_end(200, ok);
    tests++;
    if (!ok || n_rd != 3 || n_done != 1 || oerr_crc !== 1'b0) begin
      fails++; $display("FAIL crc2_retry got rd=%0d done=%0d crc=%b want 3/1/0", n_rd, n_done, oerr_crc);
    end
    tick();
    clear();
    n_fail = 4;
    req(1, 0, 8'd1);
    run_end(200, ok);
    tests++;
    if (!ok || n_rd != 4 || n_err != 1 || n_done != 0) begin
      fails++; $display("FAIL crc4_abort got rd=%0d err=%0d done=%0d want 4/1/0", n_rd, n_err, n_done);
    end
    tests++;
    if (oerr_crc !== 1'b1 || oerr_timeout !== 1'b0 || oblk_cnt !== 8'd0) begin
      fails++; $display("FAIL crc4_flags got crc=%b to=%b cnt=%0d want 1/0/0", oerr_crc, oerr_timeout, oblk_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    clear();
    respond = 0;
    req(1, 0, 8'd1);
    run_end(300, ok);
    tests++;
    if (!ok || start_cyc.size() != 1 || err_cyc != start_cyc[0] + 101) begin
      fails++; $display("FAIL to_latency got ok=%0d err_cyc=%0d want start+101", ok, err_cyc);
    end
    tick();
    tests++;
    if (obusy !== 1'b0 || oerr_timeout !== 1'b1 || oerr_crc !== 1'b0) begin
      fails++; $display("FAIL to_flags got busy=%b to=%b crc=%b want 0/1/0", obusy, oerr_timeout, oerr_crc);
    end
    respond = 1; delay = 2; n_fail = 0;
    clear();
    req(1, 0, 8'd1);
    tests++;
    if (oerr_timeout !== 1'b0 || obusy !== 1'b1) begin
      fails++; $display("FAIL to_clear got to=%b busy=%b want 0/1", oerr_timeout, obusy);
    end
    run_end(100, ok);
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear();
    respond = 1; delay = 6; busy_lo = 3; n_fail = 0;
    req(1, 1, 8'd0);
    tick(); tick();
    req(0, 1, 8'd5);
    run_end(200, ok);
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (!ok || n_rd != 1 || n_wr != 0 || n_done != 1) begin
      fails++; $display("FAIL tie_ignore got rd=%0d wr=%0d done=%0d want 1/0/1", n_rd, n_wr, n_done);
    end
    tests++;
    if (oblk_cnt !== 8'd1 || obusy !== 1'b0) begin
      fails++; $display("FAIL tie_cnt got cnt=%0d busy=%b want 1/0", oblk_cnt, obusy);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    clear();
    respond = 1; delay = 10; busy_lo = 0; n_fail = 0;
    req(1, 0, 8'd3);
    guard = 0;
    while (start_cyc.size() < 2 && guard < 200) begin
      tick();
      guard++;
    end
    tick(); tick();
    tests++;
    if (start_cyc.size() != 2 || oblk_cnt !== 8'd1 || obusy !== 1'b1) begin
      fails++; $display("FAIL rst_pre got starts=%0d cnt=%0d busy=%b want 2/1/1", start_cyc.size(), oblk_cnt, obusy);
    end
    respond = 0;
    wait_c = -1;
    irst = 0;
    tick();
    irst = 1;
    tests++;
    if ({ostart_read, ostart_write, obusy, odone, oerror,
         oerr_crc, oerr_timeout, oblk_cnt} !== 15'd0) begin
      fails++; $display("FAIL rst_mid got busy=%b cnt=%0d want all 0", obusy, oblk_cnt);
    end
    for (int i = 0; i < 30; i++) tick();
    tests++;
    if (n_rd != 2 || obusy !== 1'b0 || n_done != 0) begin
      fails++; $display("FAIL rst_nostart got rd=%0d busy=%b done=%0d want 2/0/0", n_rd, obusy, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_read_multi();
    test_write_busy();
    test_crc_retry();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
